// File: rtl/score_keeper_pkg.sv
// Shared constants and types for the Pong match-state controller.
package score_keeper_pkg;

   localparam int SCORE_W              = 3;
   localparam int PAUSE_W              = 8;
   localparam int BLINK_W              = 5;
   localparam int DEFAULT_WIN_SCORE    = 7;
   localparam int DEFAULT_PAUSE_FRAMES = 60;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SERVE    = 2'd1,
      ST_PLAY     = 2'd2,
      ST_GAMEOVER = 2'd3
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } serve_dir_t;

   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return s + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/score_keeper_frame_timer.sv
// Frame-tick counter with synchronous clear; done pulses on the tick that reaches the compare value.
module frame_timer
   import score_keeper_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               tick,
   input  logic [PAUSE_W-1:0] compare,
   output logic               done
);

   logic [PAUSE_W-1:0] count_q, count_d;

   // Counter never holds the compare value; it wraps to zero on the terminal tick.
   always_comb begin
      count_d = count_q;
      done    = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (tick) begin
         if (count_q + PAUSE_W'(1) == compare) begin
            done    = 1'b1;
            count_d = '0;
         end else begin
            count_d = count_q + PAUSE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/score_keeper.sv
// Pong match-state controller: scores, serve pacing, ball freeze and game-over handling.
// Optional winner-digit blinking in game over is built when SCORE_BLINK_EN is defined.
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
   parameter int PAUSE_FRAMES = DEFAULT_PAUSE_FRAMES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               goal_left,
   input  logic               goal_right,
   input  logic               new_game,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               win_left,
   output logic               win_right,
   output logic               ball_freeze,
   output logic               serve_req,
   output logic               serve_dir,
   output logic               blank_left,
   output logic               blank_right
);

   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [PAUSE_W-1:0] PAUSE_VAL = PAUSE_W'(PAUSE_FRAMES);

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_left_q, score_left_d;
   logic [SCORE_W-1:0] score_right_q, score_right_d;
   logic               win_left_q, win_left_d;
   logic               win_right_q, win_right_d;
   logic               freeze_q, freeze_d;
   logic               serve_req_q, serve_req_d;
   serve_dir_t         serve_dir_q, serve_dir_d;
   logic               pause_done;
   logic               pause_clear;

   // Timer is held cleared outside SERVE, so the tick arriving with SERVE entry is never counted.
   assign pause_clear = new_game || (state_q != ST_SERVE);

   frame_timer u_pause (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (pause_clear),
      .tick    (frame_tick),
      .compare (PAUSE_VAL),
      .done    (pause_done)
   );

   always_comb begin
      state_d       = state_q;
      score_left_d  = score_left_q;
      score_right_d = score_right_q;
      win_left_d    = win_left_q;
      win_right_d   = win_right_q;
      serve_dir_d   = serve_dir_q;
      serve_req_d   = 1'b0;

      if (new_game) begin
         state_d       = ST_SERVE;
         score_left_d  = '0;
         score_right_d = '0;
         win_left_d    = 1'b0;
         win_right_d   = 1'b0;
         serve_dir_d   = DIR_RIGHT;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_SERVE: begin
               if (pause_done) begin
                  serve_req_d = 1'b1;
                  state_d     = ST_PLAY;
               end
            end
            ST_PLAY: begin
               // goal_left takes precedence when both edges report in one cycle.
               if (goal_left) begin
                  score_right_d = score_inc(score_right_q);
                  if (score_right_d == WIN_VAL) begin
                     win_right_d = 1'b1;
                     state_d     = ST_GAMEOVER;
                  end else begin
                     serve_dir_d = DIR_LEFT;
                     state_d     = ST_SERVE;
                  end
               end else if (goal_right) begin
                  score_left_d = score_inc(score_left_q);
                  if (score_left_d == WIN_VAL) begin
                     win_left_d = 1'b1;
                     state_d    = ST_GAMEOVER;
                  end else begin
                     serve_dir_d = DIR_RIGHT;
                     state_d     = ST_SERVE;
                  end
               end
            end
            ST_GAMEOVER: ;
            default: state_d = ST_IDLE;
         endcase
      end

      freeze_d = (state_d != ST_PLAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         score_left_q  <= '0;
         score_right_q <= '0;
         win_left_q    <= 1'b0;
         win_right_q   <= 1'b0;
         freeze_q      <= 1'b1;
         serve_req_q   <= 1'b0;
         serve_dir_q   <= DIR_LEFT;
      end else begin
         state_q       <= state_d;
         score_left_q  <= score_left_d;
         score_right_q <= score_right_d;
         win_left_q    <= win_left_d;
         win_right_q   <= win_right_d;
         freeze_q      <= freeze_d;
         serve_req_q   <= serve_req_d;
         serve_dir_q   <= serve_dir_d;
      end
   end

`ifdef SCORE_BLINK_EN
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blank_left_q, blank_left_d;
   logic               blank_right_q, blank_right_d;

   // Counter only survives while staying in GAMEOVER; the winner's digit follows its MSB.
   always_comb begin
      blink_cnt_d = '0;
      if (state_q == ST_GAMEOVER && state_d == ST_GAMEOVER)
         blink_cnt_d = blink_cnt_q + BLINK_W'(frame_tick);
      blank_left_d  = (state_d == ST_GAMEOVER) && win_left_d  && blink_cnt_d[BLINK_W-1];
      blank_right_d = (state_d == ST_GAMEOVER) && win_right_d && blink_cnt_d[BLINK_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q   <= '0;
         blank_left_q  <= 1'b0;
         blank_right_q <= 1'b0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blank_left_q  <= blank_left_d;
         blank_right_q <= blank_right_d;
      end
   end

   assign blank_left  = blank_left_q;
   assign blank_right = blank_right_q;
`else
   assign blank_left  = 1'b0;
   assign blank_right = 1'b0;
`endif

   assign score_left  = score_left_q;
   assign score_right = score_right_q;
   assign win_left    = win_left_q;
   assign win_right   = win_right_q;
   assign ball_freeze = freeze_q;
   assign serve_req   = serve_req_q;
   assign serve_dir   = serve_dir_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with WIN_SCORE=7 and PAUSE_FRAMES=3.
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       goal_left = 1'b0;
   logic       goal_right = 1'b0;
   logic       new_game = 1'b0;
   logic [2:0] score_left;
   logic [2:0] score_right;
   logic       win_left;
   logic       win_right;
   logic       ball_freeze;
   logic       serve_req;
   logic       serve_dir;
   logic       blank_left;
   logic       blank_right;

   int total = 0;
   int bad   = 0;

`ifdef SCORE_BLINK_EN
   localparam logic BLINK_ON = 1'b1;
`else
   localparam logic BLINK_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   score_keeper #(
      .WIN_SCORE    (7),
      .PAUSE_FRAMES (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .goal_left   (goal_left),
      .goal_right  (goal_right),
      .new_game    (new_game),
      .score_left  (score_left),
      .score_right (score_right),
      .win_left    (win_left),
      .win_right   (win_right),
      .ball_freeze (ball_freeze),
      .serve_req   (serve_req),
      .serve_dir   (serve_dir),
      .blank_left  (blank_left),
      .blank_right (blank_right)
   );

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkScore(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and are sampled at the next one.
   task automatic applyStimulus(input logic ng, input logic gl, input logic gr, input logic ft);
      new_game   = ng;
      goal_left  = gl;
      goal_right = gr;
      frame_tick = ft;
      @(posedge clk);
      #1;
      new_game   = 1'b0;
      goal_left  = 1'b0;
      goal_right = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic doServe(input string tag);
      applyStimulus(0, 0, 0, 1);
      checkOutput({tag, "_req_t1"}, serve_req, 1'b0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput({tag, "_req_t3"}, serve_req, 1'b1);
      checkOutput({tag, "_frz_t3"}, ball_freeze, 1'b0);
   endtask

   initial begin
      #12;
      checkScore ("rst_score_l", score_left, 3'd0);
      checkScore ("rst_score_r", score_right, 3'd0);
      checkOutput("rst_win_l", win_left, 1'b0);
      checkOutput("rst_win_r", win_right, 1'b0);
      checkOutput("rst_freeze", ball_freeze, 1'b1);
      checkOutput("rst_req", serve_req, 1'b0);
      checkOutput("rst_dir", serve_dir, 1'b0);
      checkOutput("rst_blank_l", blank_left, 1'b0);
      checkOutput("rst_blank_r", blank_right, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(0, 0, 1, 0);
      checkScore("idle_goal_ignored", score_left, 3'd0);

      // new_game together with a frame tick: that tick must not count
      applyStimulus(1, 0, 0, 1);
      checkOutput("ng_freeze", ball_freeze, 1'b1);
      checkOutput("ng_dir", serve_dir, 1'b1);
      checkOutput("ng_req", serve_req, 1'b0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("srv_t1", serve_req, 1'b0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("srv_gap", serve_req, 1'b0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("srv_t2", serve_req, 1'b0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("srv_t3_req", serve_req, 1'b1);
      checkOutput("srv_t3_frz", ball_freeze, 1'b0);
      checkOutput("srv_t3_dir", serve_dir, 1'b1);
      applyStimulus(0, 0, 0, 0);
      checkOutput("srv_req_one_cycle", serve_req, 1'b0);
      checkOutput("play_freeze", ball_freeze, 1'b0);

      applyStimulus(0, 0, 1, 0);
      checkScore ("gr_score_l", score_left, 3'd1);
      checkScore ("gr_score_r", score_right, 3'd0);
      checkOutput("gr_dir", serve_dir, 1'b1);
      checkOutput("gr_freeze", ball_freeze, 1'b1);

      doServe("s2");
      applyStimulus(0, 1, 0, 0);
      checkScore ("gl_score_r", score_right, 3'd1);
      checkOutput("gl_dir", serve_dir, 1'b0);
      checkOutput("gl_freeze", ball_freeze, 1'b1);

      doServe("s3");
      applyStimulus(0, 1, 1, 0);
      checkScore("both_score_r", score_right, 3'd2);
      checkScore("both_score_l", score_left, 3'd1);
      checkOutput("both_dir", serve_dir, 1'b0);

      // new_game mid-pause restarts the count from zero
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0);
      checkScore ("abort_score_l", score_left, 3'd0);
      checkScore ("abort_score_r", score_right, 3'd0);
      checkOutput("abort_dir", serve_dir, 1'b1);
      doServe("abort");

      applyStimulus(1, 1, 0, 0);
      checkScore ("ng_prio_score_r", score_right, 3'd0);
      checkOutput("ng_prio_freeze", ball_freeze, 1'b1);
      checkOutput("ng_prio_dir", serve_dir, 1'b1);

      for (int i = 0; i < 6; i++) begin
         doServe("r_up");
         applyStimulus(0, 1, 0, 0);
      end
      checkScore ("r6_score", score_right, 3'd6);
      checkOutput("r6_win", win_right, 1'b0);
      doServe("r7");
      applyStimulus(0, 1, 0, 0);
      checkScore ("r7_score", score_right, 3'd7);
      checkOutput("r7_win_r", win_right, 1'b1);
      checkOutput("r7_win_l", win_left, 1'b0);
      checkOutput("r7_freeze", ball_freeze, 1'b1);
      applyStimulus(0, 1, 0, 0);
      checkScore("go_gl_held", score_right, 3'd7);
      applyStimulus(0, 0, 1, 0);
      checkScore("go_gr_held", score_left, 3'd0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
      checkOutput("go_no_serve", serve_req, 1'b0);
      checkOutput("go_win_held", win_right, 1'b1);
      checkOutput("go_blank_l", blank_left, 1'b0);

      applyStimulus(1, 0, 0, 0);
      checkScore ("go_ng_score_r", score_right, 3'd0);
      checkOutput("go_ng_win_r", win_right, 1'b0);
      checkOutput("go_ng_freeze", ball_freeze, 1'b1);
      checkOutput("go_ng_dir", serve_dir, 1'b1);
      doServe("go_ng");

      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         doServe("l_up");
         applyStimulus(0, 0, 1, 0);
      end
      checkScore ("l7_score", score_left, 3'd7);
      checkOutput("l7_win_l", win_left, 1'b1);
      checkOutput("l7_win_r", win_right, 1'b0);

      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1);
      checkOutput("blink15_l", blank_left, 1'b0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("blink16_l", blank_left, BLINK_ON);
      checkOutput("blink16_r", blank_right, 1'b0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("blink16_hold", blank_left, BLINK_ON);
      for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1);
      checkOutput("blink32_l", blank_left, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1);
      checkOutput("blink48_l", blank_left, BLINK_ON);

      // asynchronous reset mid-cycle, checked before any clock edge
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkScore ("async_rst_score_l", score_left, 3'd0);
      checkOutput("async_rst_win_l", win_left, 1'b0);
      checkOutput("async_rst_freeze", ball_freeze, 1'b1);
      checkOutput("async_rst_dir", serve_dir, 1'b0);
      checkOutput("async_rst_blank_l", blank_left, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
